// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline debug controller: command bytes,
// controller states and the layout of the snapshot dump.
package debug_pkg;

  // Snapshot geometry
  localparam int NUM_REGS    = 32;
  localparam int MEM_WORDS   = 32;
  localparam int TOTAL_WORDS = 1 + NUM_REGS + MEM_WORDS + 1;
  localparam int IDX_W       = 7;

  // Word-index boundaries of each dump section
  localparam logic [IDX_W-1:0] WIDX_PC        = IDX_W'(0);
  localparam logic [IDX_W-1:0] WIDX_REG_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] WIDX_MEM_FIRST = IDX_W'(1 + NUM_REGS);
  localparam logic [IDX_W-1:0] WIDX_CNT       = IDX_W'(1 + NUM_REGS + MEM_WORDS);

  // Host command bytes
  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'
  localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'

  // Controller states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RUN  = 3'd1;
  localparam state_t ST_STEP = 3'd2;
  localparam state_t ST_LOAD = 3'd3;
  localparam state_t ST_WAIT = 3'd4;
  localparam state_t ST_SEND = 3'd5;

  // Which source feeds a given dump word
  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_REG = 2'd1,
    SEC_MEM = 2'd2,
    SEC_CNT = 2'd3
  } section_e;

  function automatic section_e word_section(input logic [IDX_W-1:0] idx);
    if (idx == WIDX_PC) begin
      return SEC_PC;
    end else if (idx < WIDX_MEM_FIRST) begin
      return SEC_REG;
    end else if (idx < WIDX_CNT) begin
      return SEC_MEM;
    end else begin
      return SEC_CNT;
    end
  endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Takes one 32-bit word and hands it out MSB-first as four bytes over a
// valid/ready handshake; done_o pulses on the accept of the fourth byte.
module debug_word_serializer
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [7:0]  byte_o,
  output logic        done_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        accept;

  assign accept = valid_q && ready_i;

  // Load a fresh word, or shift the next byte up to the top on each accept
  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      cnt_d   = 2'd0;
      valid_d = 1'b1;
    end else if (accept) begin
      word_d = {word_q[23:0], 8'h00};
      cnt_d  = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        valid_d = 1'b0;
      end
    end
  end

  // Serializer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= 32'h0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign byte_o  = word_q[31:24];
  assign done_o  = accept && (cnt_q == 2'd3);

endmodule

// File: rtl/debug_unit.sv
// Host debug controller for the MIPS pipeline: decodes UART commands,
// gates the pipeline clock for run/step, counts executed cycles and
// streams a PC/register/memory/cycle-count snapshot back over the UART.
//
// state | meaning
// IDLE  | waiting for a command byte
// RUN   | pipeline free-running until halt or 'h'
// STEP  | one enabled pipeline cycle
// LOAD  | select the source of the current dump word
// WAIT  | source settled; word latched into the serializer
// SEND  | four bytes of the word handed to the transmitter
module debug_unit
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        pipe_clk_en,
  input  logic        halt,
  input  logic [31:0] pc_value,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        debug_mode,
  output logic [31:0] debug_addr,
  input  logic [31:0] mem_data,
  output logic        busy
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      cyc_q;
  section_e         sec;
  logic             stop_req;
  logic             last_word;
  logic             dump_phase;
  logic             ser_load;
  logic             ser_done;
  logic [31:0]      ser_word;

  assign sec        = word_section(idx_q);
  assign last_word  = (idx_q == WIDX_CNT);
  assign stop_req   = halt || (rx_valid && (rx_data == CMD_HALT));
  assign dump_phase = (state_q == ST_LOAD) || (state_q == ST_WAIT) ||
                      (state_q == ST_SEND);

  // Command decode and dump sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_LOAD;
        end
      end
      ST_STEP: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_SEND;
      ST_SEND: begin
        if (ser_done) begin
          if (last_word) begin
            state_d = ST_IDLE;
            idx_d   = WIDX_PC;
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = WIDX_PC;
      end
    endcase
  end

  // FSM state and dump word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= WIDX_PC;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Executed-cycle counter; wraps naturally, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'h0;
    end else if (pipe_clk_en) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  // Word source mux; memory data is one cycle behind debug_addr, so it is
  // only sampled in WAIT, after LOAD has held the address for a cycle
  always_comb begin
    ser_word = 32'h0;
    case (sec)
      SEC_PC:  ser_word = pc_value;
      SEC_REG: ser_word = reg_data;
      SEC_MEM: ser_word = mem_data;
      SEC_CNT: ser_word = cyc_q;
      default: ser_word = 32'h0;
    endcase
  end

  assign ser_load = (state_q == ST_WAIT);

  debug_word_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .word_i  (ser_word),
    .ready_i (tx_ready),
    .valid_o (tx_valid),
    .byte_o  (tx_data),
    .done_o  (ser_done)
  );

  // Source selects are decoded straight from the word index so they drop
  // together with the state registers on an asynchronous reset
  assign reg_sel     = (sec == SEC_REG) ? 5'(idx_q - WIDX_REG_FIRST) : 5'd0;
  assign debug_mode  = dump_phase && (sec == SEC_MEM);
  assign debug_addr  = debug_mode ? 32'(idx_q - WIDX_MEM_FIRST) : 32'h0;
  assign pipe_clk_en = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
module tb_debug_unit;

  localparam int NBYTES = 264;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        pipe_clk_en;
  logic        halt;
  logic [31:0] pc_value;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        debug_mode;
  logic [31:0] debug_addr;
  logic [31:0] mem_data;
  logic        busy;

  logic [31:0] regs [0:31];
  logic [31:0] mem  [0:31];
  logic [31:0] exp_cycles;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          en_cnt   = 0;

  logic [7:0]  got_b  [0:NBYTES-1];
  logic        got_dm [0:NBYTES-1];
  int          got_n;
  int          first_k;

  always #5 clk = ~clk;

  debug_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .pipe_clk_en (pipe_clk_en),
    .halt        (halt),
    .pc_value    (pc_value),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data),
    .debug_mode  (debug_mode),
    .debug_addr  (debug_addr),
    .mem_data    (mem_data),
    .busy        (busy)
  );

  // Pipeline-side models: combinational register file, one-cycle memory
  assign reg_data = regs[reg_sel];
  always @(posedge clk)
    mem_data <= (debug_mode && debug_addr < 32) ? mem[debug_addr[4:0]] : 32'hBAD0_0BAD;

  always @(negedge clk) if (pipe_clk_en === 1'b1) en_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference snapshot: the words in dump order, bytes MSB first
  function automatic logic [31:0] exp_word(input int w);
    if (w == 0) return pc_value;
    if (w <= 32) return regs[w-1];
    if (w <= 64) return mem[w-33];
    return exp_cycles;
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = exp_word(i / 4);
    return w[8*(3 - (i % 4)) +: 8];
  endfunction

  task automatic randomize_state();
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      mem[i]  = $urandom;
    end
    pc_value = $urandom;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Collects one dump; k counts cycles from the call (k=0 is the current cycle)
  task automatic capture_dump(input bit rand_ready, input int inject_k, input logic [7:0] inject_b);
    bit         pv, pr;
    logic [7:0] pd;
    int         k;
    bit         exp_v;
    got_n = 0; first_k = -1; pv = 0; pr = 0; pd = 8'h00; k = 0;
    while (got_n < NBYTES && k < 4000) begin
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == inject_k) begin
        rx_data  = inject_b;
        rx_valid = 1'b1;
      end
      @(negedge clk);
      if (k >= 1) begin
        n_checks++;
        if (pipe_clk_en !== 1'b0) begin
          n_fail++;
          $display("FAIL clk_en_during_dump k=%0d got=%b want=0", k, pipe_clk_en);
        end
      end
      if (pv && !pr) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          n_fail++;
          $display("FAIL tx_hold k=%0d got valid=%b data=%h want valid=1 data=%h", k, tx_valid, tx_data, pd);
        end
      end else if (pv && pr) begin
        exp_v = (got_n % 4) != 0;
        n_checks++;
        if (tx_valid !== exp_v) begin
          n_fail++;
          $display("FAIL tx_valid_after_accept byte=%0d got=%b want=%b", got_n, tx_valid, exp_v);
        end
      end
      if (tx_valid === 1'b1 && first_k < 0) first_k = k;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        got_b[got_n]  = tx_data;
        got_dm[got_n] = debug_mode;
        got_n++;
      end
      pv = (tx_valid === 1'b1);
      pr = tx_ready;
      pd = tx_data;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      k++;
    end
    tx_ready = 1'b1;
    n_checks++;
    if (got_n != NBYTES) begin
      n_fail++;
      $display("FAIL dump_length got=%0d want=%0d", got_n, NBYTES);
    end
  endtask

  task automatic check_dump(input string name, input int want_first_k);
    logic [7:0] eb;
    logic       edm;
    n_checks++;
    if (first_k != want_first_k) begin
      n_fail++;
      $display("FAIL %s first_tx_valid got=k%0d want=k%0d", name, first_k, want_first_k);
    end
    for (int i = 0; i < got_n; i++) begin
      eb  = exp_byte(i);
      edm = (i >= 132 && i < 260);
      n_checks++;
      if (got_b[i] !== eb) begin
        n_fail++;
        $display("FAIL %s byte[%0d] got=%h want=%h", name, i, got_b[i], eb);
      end
      n_checks++;
      if (got_dm[i] !== edm) begin
        n_fail++;
        $display("FAIL %s debug_mode@byte[%0d] got=%b want=%b", name, i, got_dm[i], edm);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_dump got=%b want=0", name, busy);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if ({tx_data, tx_valid, pipe_clk_en, reg_sel, debug_mode, debug_addr, busy} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs got tx_data=%h tx_valid=%b en=%b reg_sel=%0d dm=%b addr=%h busy=%b want all 0",
               name, tx_data, tx_valid, pipe_clk_en, reg_sel, debug_mode, debug_addr, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_outputs_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cycles = 32'd0;
  endtask

  task automatic test_dump();
    randomize_state();
    send_cmd(8'h64);
    capture_dump(1'b0, -1, 8'h00);
    check_dump("dump", 2);
  endtask

  task automatic test_ignored_cmd();
    int e0;
    e0 = en_cnt;
    send_cmd(8'h78);
    send_cmd(8'h68);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || en_cnt != e0) begin
      n_fail++;
      $display("FAIL ignored_cmd got busy=%b en_cycles=%0d want busy=0 en_cycles=0", busy, en_cnt - e0);
    end
  endtask

  task automatic test_step();
    int e0;
    for (int s = 0; s < 3; s++) begin
      randomize_state();
      e0 = en_cnt;
      send_cmd(8'h73);
      capture_dump(1'b0, -1, 8'h00);
      exp_cycles = exp_cycles + 32'd1;
      n_checks++;
      if (en_cnt - e0 != 1) begin
        n_fail++;
        $display("FAIL step%0d enabled_cycles got=%0d want=1", s, en_cnt - e0);
      end
      check_dump($sformatf("step%0d", s), 3);
    end
    n_checks++;
    if ({got_b[260], got_b[261], got_b[262], got_b[263]} !== 32'd3) begin
      n_fail++;
      $display("FAIL step_count got=%h%h%h%h want=00000003", got_b[260], got_b[261], got_b[262], got_b[263]);
    end
  endtask

  task automatic test_run_halt();
    int e0;
    randomize_state();
    halt = 1'b0;
    e0 = en_cnt;
    send_cmd(8'h63);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (pipe_clk_en !== 1'b1) begin
        n_fail++;
        $display("FAIL run_enable cycle=%0d got=%b want=1", i + 1, pipe_clk_en);
      end
      @(posedge clk); #1;
    end
    halt = 1'b1;
    capture_dump(1'b0, -1, 8'h00);
    halt = 1'b0;
    exp_cycles = exp_cycles + 32'd11;
    n_checks++;
    if (en_cnt - e0 != 11) begin
      n_fail++;
      $display("FAIL run_halt enabled_cycles got=%0d want=11", en_cnt - e0);
    end
    check_dump("run_halt", 3);
  endtask

  task automatic test_halt_preset();
    int e0;
    randomize_state();
    halt = 1'b1;
    e0 = en_cnt;
    send_cmd(8'h63);
    capture_dump(1'b0, -1, 8'h00);
    halt = 1'b0;
    exp_cycles = exp_cycles + 32'd1;
    n_checks++;
    if (en_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL halt_preset enabled_cycles got=%0d want=1", en_cnt - e0);
    end
    check_dump("halt_preset", 3);
  endtask

  task automatic test_host_stop();
    int e0;
    int e1;
    randomize_state();
    e0 = en_cnt;
    send_cmd(8'h63);
    repeat (4) @(posedge clk);
    #1;
    rx_data  = 8'h68;
    rx_valid = 1'b1;
    capture_dump(1'b0, 100, 8'h73);
    exp_cycles = exp_cycles + 32'd5;
    e1 = en_cnt;
    n_checks++;
    if (e1 - e0 != 5) begin
      n_fail++;
      $display("FAIL host_stop enabled_cycles got=%0d want=5", e1 - e0);
    end
    check_dump("host_stop", 3);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || en_cnt != e1) begin
      n_fail++;
      $display("FAIL step_mid_dump_ignored got busy=%b en_cycles=%0d want busy=0 en_cycles=0", busy, en_cnt - e1);
    end
  endtask

  task automatic test_backpressure();
    randomize_state();
    regs[7] = 32'hDEADBEEF;
    send_cmd(8'h64);
    capture_dump(1'b1, -1, 8'h00);
    n_checks++;
    if ({got_b[32], got_b[33], got_b[34], got_b[35]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL reg7_bytes got=%h%h%h%h want=deadbeef", got_b[32], got_b[33], got_b[34], got_b[35]);
    end
    check_dump("backpressure", 2);
  endtask

  task automatic test_reset_mid();
    send_cmd(8'h63);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_run");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cycles = 32'd0;
    randomize_state();
    tx_ready = 1'b1;
    send_cmd(8'h64);
    repeat (220) @(posedge clk);
    #3;
    n_checks++;
    if (debug_mode !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_dump_state got dm=%b busy=%b want dm=1 busy=1", debug_mode, busy);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_dump");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    randomize_state();
    send_cmd(8'h64);
    capture_dump(1'b0, -1, 8'h00);
    check_dump("after_reset", 2);
  endtask

  initial begin
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    halt     = 1'b0;
    pc_value = 32'h0;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h0;
      mem[i]  = 32'h0;
    end
    test_reset();
    test_dump();
    test_ignored_cmd();
    test_step();
    test_run_halt();
    test_halt_preset();
    test_host_stop();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
